// File: rtl/filter_pkg.sv
// Shared filter-chain definitions: in_demux parameter defaults, the phase
// state type and the phase-to-lane routing used by the input demultiplexer.
package filter_pkg;

  localparam int LANES_DEF      = 3;
  localparam int IN_W_DEF       = 11;
  localparam int ACC_W_DEF      = 36;
  localparam int FRAC_SHIFT_DEF = 24;

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2
  } phase_e;

  // Lane order 0, 2, 1 matches the downstream serializer's read order.
  function automatic int phase_lane(input phase_e ph);
    case (ph)
      PH0:     return 0;
      PH1:     return 2;
      PH2:     return 1;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/in_demux_phase.sv
// Frame-position FSM for in_demux: advances one phase per accepted sample,
// restarts on sync, and flags the accepted sample that completes a frame.
module in_demux_phase
  import filter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       sync,
  output logic [1:0] phase,
  output logic       frame_done
);

  phase_e state_q;
  phase_e state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= PH0;
    else       state_q <= state_d;
  end

  // A sync with a sample restarts the frame on that sample, so it never completes one.
  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    if (sync && !in_valid) begin
      state_d = PH0;
    end else if (in_valid) begin
      if (sync) begin
        state_d = PH1;
      end else begin
        case (state_q)
          PH0:     state_d = PH1;
          PH1:     state_d = PH2;
          PH2: begin
            state_d    = PH0;
            frame_done = 1'b1;
          end
          default: state_d = PH0;
        endcase
      end
    end
  end

  assign phase = state_q;

endmodule

// File: rtl/in_demux.sv
// Serial-to-parallel polyphase input demultiplexer: scales samples into lane
// words and presents a full frame on Out with a one-cycle out_valid strobe.
// Build option: IN_DEMUX_CLIP_EN maps the most negative input to its symmetric value.
module in_demux
  import filter_pkg::*;
#(
  parameter int LANES      = LANES_DEF,
  parameter int IN_W       = IN_W_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int FRAC_SHIFT = FRAC_SHIFT_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [IN_W-1:0]  In,
  input  logic                    in_valid,
  input  logic                    sync,
  output logic signed [ACC_W-1:0] Out [0:LANES-1],
  output logic                    out_valid,
  output logic [1:0]              phase
);

  function automatic logic signed [IN_W-1:0] clip_in(input logic signed [IN_W-1:0] x);
`ifdef IN_DEMUX_CLIP_EN
    logic signed [IN_W-1:0] most_neg;
    most_neg = {1'b1, {(IN_W-1){1'b0}}};
    return (x == most_neg) ? {1'b1, {(IN_W-2){1'b0}}, 1'b1} : x;
`else
    return x;
`endif
  endfunction

  function automatic logic signed [ACC_W-1:0] form_word(input logic signed [IN_W-1:0] x);
    logic signed [ACC_W-1:0] ext;
    ext = ACC_W'(x);
    return ext <<< FRAC_SHIFT;
  endfunction

  logic                    frame_done;
  int                      wr_lane;
  logic signed [ACC_W-1:0] word_p0;
  logic signed [ACC_W-1:0] stage_p1 [0:LANES-1];
  logic                    vld_p1;

  in_demux_phase u_phase (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .sync       (sync),
    .phase      (phase),
    .frame_done (frame_done)
  );

  // Stage p0: lane selection and word formation for the incoming sample
  always_comb begin
    wr_lane = sync ? 0 : phase_lane(phase_e'(phase));
    word_p0 = form_word(clip_in(In));
  end

  // Stage p1: staging lanes, and the frame-complete transfer to Out that
  // bypasses the final sample straight in so the strobe lands one clock later.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        stage_p1[i] <= '0;
        Out[i]      <= '0;
      end
    end else begin
      vld_p1 <= frame_done;
      if (sync && !in_valid) begin
        for (int i = 0; i < LANES; i++) stage_p1[i] <= '0;
      end else if (in_valid) begin
        for (int i = 0; i < LANES; i++) begin
          if (i == wr_lane) stage_p1[i] <= word_p0;
          else if (sync)    stage_p1[i] <= '0;
        end
      end
      if (frame_done) begin
        for (int i = 0; i < LANES; i++)
          Out[i] <= (i == wr_lane) ? word_p0 : stage_p1[i];
      end
    end
  end

  assign out_valid = vld_p1;

endmodule

// File: tb/tb_in_demux.sv
// Bench for in_demux: directed frame scenarios plus randomized traffic checked
// against a frame-slot reference model.
module tb_in_demux;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic signed [10:0]  din = '0;
  logic                in_valid = 1'b0;
  logic                sync = 1'b0;
  logic signed [35:0]  dout [0:2];
  logic                out_valid;
  logic [1:0]          phase;

  in_demux dut (
    .clk       (clk),
    .reset     (reset),
    .In        (din),
    .in_valid  (in_valid),
    .sync      (sync),
    .Out       (dout),
    .out_valid (out_valid),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference model: samples are collected in frame order; the k-th sample of
  // a frame lands in lane {0,2,1}[k]; a full frame appears on Out one clock later.
  int     m_cnt = 0;
  longint m_slot [0:2];
  longint m_out  [0:2];
  bit     m_vld = 0;
  int     lane_of_slot [0:2] = '{0, 2, 1};
  int     strobes = 0;
  int     cyc = 0;

  function automatic longint exp_word(input int x);
    int     v;
    longint p;
    v = x;
`ifdef IN_DEMUX_CLIP_EN
    if (v == -1024) v = -1023;
`endif
    p = longint'(v) * 64'sd16777216;
    return p;
  endfunction

  task automatic step(input int x, input bit v, input bit s, input bit r);
    din      = 11'(x);
    in_valid = v;
    sync     = s;
    reset    = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      m_cnt = 0;
      m_vld = 0;
      for (int i = 0; i < 3; i++) m_out[i] = 0;
    end else begin
      m_vld = 0;
      if (s) m_cnt = 0;
      if (v) begin
        m_slot[m_cnt] = exp_word(x);
        m_cnt++;
        if (m_cnt == 3) begin
          for (int k = 0; k < 3; k++) m_out[lane_of_slot[k]] = m_slot[k];
          m_vld = 1;
          m_cnt = 0;
        end
      end
    end
    #1;
    chk("out_valid", longint'(out_valid), longint'(m_vld));
    chk("phase", longint'(phase), longint'(m_cnt));
    chk("lane0", dout[0], m_out[0]);
    chk("lane1", dout[1], m_out[1]);
    chk("lane2", dout[2], m_out[2]);
    if (out_valid) strobes++;
  endtask

  int s0;
  int last;
  int x;

  initial begin
    #1;
    // reset state
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // single frame 5, 7, -3
    s0 = strobes;
    step(5, 1, 0, 0);
    step(7, 1, 0, 0);
    step(-3, 1, 0, 0);
    chk("sf_l0", dout[0], 64'sd83886080);
    chk("sf_l2", dout[2], 64'sd117440512);
    chk("sf_l1", dout[1], 36'shFFD000000);
    step(0, 0, 0, 0);
    chk("sf_strobes", strobes - s0, 1);

    // gapped input
    s0 = strobes;
    step(1, 1, 0, 0);
    step(9, 0, 0, 0);
    step(9, 0, 0, 0);
    step(2, 1, 0, 0);
    step(9, 0, 0, 0);
    step(3, 1, 0, 0);
    chk("gap_vld", longint'(out_valid), 1);
    chk("gap_l0", dout[0], 64'sd16777216);
    chk("gap_l2", dout[2], 64'sd33554432);
    chk("gap_l1", dout[1], 64'sd50331648);
    step(0, 0, 0, 0);
    chk("gap_strobes", strobes - s0, 1);

    // sync mid-frame discards the partial frame
    s0 = strobes;
    step(20, 1, 0, 0);
    step(21, 1, 0, 0);
    step(0, 0, 1, 0);
    chk("sync_phase", longint'(phase), 0);
    step(10, 1, 0, 0);
    step(11, 1, 0, 0);
    step(12, 1, 0, 0);
    chk("sync_l0", dout[0], 64'sd167772160);
    chk("sync_l2", dout[2], 64'sd184549376);
    chk("sync_l1", dout[1], 64'sd201326592);
    step(0, 0, 0, 0);
    chk("sync_strobes", strobes - s0, 1);

    // sync on the PH2 sample restarts instead of completing
    step(30, 1, 0, 0);
    step(31, 1, 0, 0);
    step(32, 1, 1, 0);
    chk("sync_ph2_vld", longint'(out_valid), 0);
    step(33, 1, 0, 0);
    step(34, 1, 0, 0);
    chk("sync_ph2_l0", dout[0], 64'sd536870912);

    // clip option on the most negative input
    step(0, 0, 1, 0);
    step(-1024, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
`ifdef IN_DEMUX_CLIP_EN
    chk("clip_l0", dout[0], -64'sd17163091968);
`else
    chk("clip_l0", dout[0], -64'sd17179869184);
`endif

    // reset held two cycles mid-frame
    step(4, 1, 0, 0);
    step(6, 1, 1, 0);
    step(0, 1, 1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("rst_vld", longint'(out_valid), 0);
    chk("rst_phase", longint'(phase), 0);
    chk("rst_l0", dout[0], 0);
    chk("rst_l1", dout[1], 0);
    chk("rst_l2", dout[2], 0);

    // continuous streaming, 300 samples
    s0 = strobes;
    last = -1;
    for (int i = 0; i < 301; i++) begin
      x = (i < 300) ? int'($urandom_range(0, 2047)) - 1024 : 0;
      step(x, (i < 300), (i == 0), 0);
      if (out_valid) begin
        if (last >= 0) chk("stream_gap", cyc - last, 3);
        last = cyc;
      end
    end
    chk("stream_strobes", strobes - s0, 100);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      x = int'($urandom_range(0, 2047)) - 1024;
      if ($urandom_range(0, 19) == 0) x = -1024;
      step(x, ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/in_demux.md
IN_DEMUX -- requirements
Module: in_demux

Interface
REQ-001 SHALL have parameter LANES, default 3: number of polyphase lanes.
REQ-002 SHALL have parameter IN_W, default 11: input sample width, signed.
REQ-003 SHALL have parameter ACC_W, default 36: lane output width, signed.
REQ-004 SHALL have parameter FRAC_SHIFT, default 24: left shift applied when a sample is placed in a lane word.
REQ-005 SHALL have port clk, input, 1: single clock for all logic.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high.
REQ-007 SHALL have port In, input, IN_W signed: serial input sample.
REQ-008 SHALL have port in_valid, input, 1: In is valid this cycle.
REQ-009 SHALL have port sync, input, 1: frame restart, forcing the next accepted sample to be the first of a frame.
REQ-010 SHALL have port Out, output, unpacked array [0:LANES-1] of ACC_W signed: parallel lane samples.
REQ-011 SHALL have port out_valid, output, 1: single-cycle strobe marking new Out contents.
REQ-012 SHALL have port phase, output, 2: current frame-position state, for debug.

Function
REQ-013 SHALL implement a phase FSM with states PH0, PH1 and PH2, encoded as 0, 1 and 2 on phase.
- PH0→PH1→PH2→PH0 on each cycle with in_valid=1.
- State holds when in_valid=0.
REQ-014 SHALL route accepted samples to staging lanes as follows:
- PH0 → lane 0.
- PH1 → lane 2.
- PH2 → lane 1.
- This matches the downstream serializer order 0, 2, 1.
REQ-015 SHALL form each lane word as In sign-extended to ACC_W and shifted left by FRAC_SHIFT:
- bits [34:24] = In.
- bit 35 = In[10].
- bits [23:0] = 0.
REQ-016 SHALL, on the cycle after the PH2 sample is accepted, load all Out lanes at once from staging and assert out_valid for exactly one cycle.
- Latency from the third accepted sample to out_valid: 1 clk.
REQ-017 SHALL hold Out stable between out_valid strobes; partial frames never alter Out.
REQ-018 SHALL, on sync=1 with in_valid=0, force the state to PH0, discard staged partial samples, and suppress any out_valid for that partial frame.
REQ-019 SHALL, on sync=1 with in_valid=1, accept In as PH0 (lane 0) and move to PH1.
REQ-020 SHALL, on sync=1 in the same cycle PH2 is accepted, give sync priority: the sample becomes PH0 and no out_valid follows.
REQ-021 SHALL allow back-to-back frames at in_valid=1 every cycle, giving out_valid once every 3 cycles with no dropped sample.

Reset
REQ-022 SHALL, on reset=1 at a clk edge, drive the following values, and a reset mid-frame discards staged samples:
- state PH0.
- phase = 0.
- out_valid = 0.
- all Out lanes = 0.
- all staging lanes = 0.
REQ-023 SHALL give reset priority over sync and in_valid.

Configuration
REQ-024 SHALL support macro IN_DEMUX_CLIP_EN:
- Defined: an accepted In of -1024 is replaced by -1023 before lane formation, giving a symmetric range.
- Undefined: In is passed unmodified.

Structure
REQ-025 SHALL take LANES, IN_W, ACC_W, FRAC_SHIFT defaults and the phase enum type from shared package filter_pkg.
REQ-026 SHALL place the phase FSM in sub-module in_demux_phase, with ports clk, reset, in_valid, sync, phase and frame_done.

Verification
REQ-027 SHALL cover reset: reset held 2 cycles mid-frame → Out all 0, out_valid=0, phase=0 the next cycle.
REQ-028 SHALL cover a single frame: In=5, 7, -3 with in_valid=1 on consecutive cycles → 1 cycle later Out[0]=5<<24, Out[2]=7<<24, Out[1]=-3<<24 (36'shFFD000000), out_valid=1 for one cycle.
REQ-029 SHALL cover gapped input: in_valid pattern 1,0,0,1,0,1 with In=1,2,3 → out_valid exactly once, the cycle after the third valid, with lanes 0/2/1 = 1/2/3 shifted.
REQ-030 SHALL cover sync mid-frame: two samples accepted, then sync=1 with in_valid=0, then 3 samples 10, 11, 12 → single out_valid with lanes 0/2/1 = 10/11/12 shifted; no strobe for the partial frame.
REQ-031 SHALL cover continuous streaming: 300 samples at in_valid=1 → 100 out_valid strobes spaced exactly 3 cycles apart, with data matching a reference model.
REQ-032 SHALL cover the clip option: In=-1024 → lane = -1023<<24 with IN_DEMUX_CLIP_EN defined, and -1024<<24 without it.
